// File: rtl/alu_res_pkg.sv
// alu_res_pkg: opcode constants and the packed result entry shared by the ALU result FIFO
package alu_res_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;
  typedef struct packed {
    logic [1:0] opcode;
    logic [7:0] y1;
    logic [7:0] y;
    logic       c;
    logic       o;
    logic       z;
    logic       n;
  } alu_res_t;
endpackage

// File: rtl/alu_result_fifo_if.sv
// alu_result_fifo_if: valid/ready write side (in_*) and FWFT read side (out_*) of the ALU result FIFO
// master: ALU producer plus consumer; slave: the FIFO
interface alu_result_fifo_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_opcode;
  logic [7:0]  in_y;
  logic [7:0]  in_y1;
  logic        in_c;
  logic        in_o;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_opcode;
  logic [15:0] out_result;
  logic        out_c;
  logic        out_o;
  logic        out_z;
  logic        out_n;
  modport master (
    output in_valid, in_opcode, in_y, in_y1, in_c, in_o, out_ready,
    input  in_ready, out_valid, out_opcode, out_result, out_c, out_o, out_z, out_n
  );
  modport slave (
    input  in_valid, in_opcode, in_y, in_y1, in_c, in_o, out_ready,
    output in_ready, out_valid, out_opcode, out_result, out_c, out_o, out_z, out_n
  );
endinterface

// File: rtl/alu_flag_gen.sv
// alu_flag_gen: sanitises raw ALU outputs per opcode and derives z/n; ports opcode,y,y1,c,o in, res out
module alu_flag_gen
  import alu_res_pkg::*;
(
  input  logic [1:0] opcode,
  input  logic [7:0] y,
  input  logic [7:0] y1,
  input  logic       c,
  input  logic       o,
  output alu_res_t   res
);
  logic mul;
  assign mul = opcode == OP_MUL;
  always_comb begin
    res        = '0;
    res.opcode = opcode;
    res.y      = y;
    res.y1     = mul ? y1 : 8'h00;
    res.c      = opcode == OP_ADD ? c : 1'b0;
    res.o      = opcode == OP_ADD ? o : 1'b0;
    res.z      = mul ? {y1, y} == 16'h0000 : y == 8'h00;
    res.n      = mul ? y1[7] : y[7];
  end
endmodule

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: FWFT FIFO of sanitised ALU results; ports clk, rst (async high), bus (slave), count
// optional ALU_RES_STATS_EN adds saturating ovf_count/cy_count of accepted pushes with o/c set
module alu_result_fifo
  import alu_res_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  alu_result_fifo_if.slave    bus,
  output logic [AW:0]         count
`ifdef ALU_RES_STATS_EN
  ,
  output logic [15:0]         ovf_count,
  output logic [15:0]         cy_count
`endif
);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  alu_res_t       mem [DEPTH];
  alu_res_t       wdata;
  alu_res_t       head;
  logic [AW-1:0]  wp;
  logic [AW-1:0]  rp;
  logic           push;
  logic           pop;
  alu_flag_gen u_flag (
    .opcode (bus.in_opcode),
    .y      (bus.in_y),
    .y1     (bus.in_y1),
    .c      (bus.in_c),
    .o      (bus.in_o),
    .res    (wdata)
  );
  assign bus.in_ready  = count != FULL;
  assign bus.out_valid = count != '0;
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;
  always_ff @(posedge clk)
    if (push) mem[wp] <= wdata;
  // power-of-two depth lets the pointers wrap on natural overflow
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  // outputs are forced to zero while empty so stale storage never leaks out
  assign head           = bus.out_valid ? mem[rp] : '0;
  assign bus.out_opcode = head.opcode;
  assign bus.out_result = {head.y1, head.y};
  assign bus.out_c      = head.c;
  assign bus.out_o      = head.o;
  assign bus.out_z      = head.z;
  assign bus.out_n      = head.n;
`ifdef ALU_RES_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ovf_count <= '0;
      cy_count  <= '0;
    end else if (push) begin
      if (wdata.o && ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
      if (wdata.c && cy_count != 16'hFFFF) cy_count <= cy_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: scoreboard bench for alu_result_fifo; expected entries queued at push, compared at head
module tb_alu_result_fifo;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] count;
  int checks = 0;
  int errors = 0;
  logic [21:0] q[$];
`ifdef ALU_RES_STATS_EN
  logic [15:0] ovf_count, cy_count;
  int m_ovf = 0, m_cy = 0;
`endif
  alu_result_fifo_if b ();
  alu_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (b),
    .count (count)
`ifdef ALU_RES_STATS_EN
    ,
    .ovf_count (ovf_count),
    .cy_count  (cy_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  // expected {opcode, result16, c, o, z, n} for a raw ALU result
  function automatic logic [21:0] model(input logic [1:0] op, input logic [7:0] y, input logic [7:0] y1,
                                         input logic c, input logic o);
    logic [15:0] r;
    logic cc, oo, z, n;
    case (op)
      2'b00:   begin r = {8'h00, y}; cc = c;    oo = o;    end
      2'b11:   begin r = {y1, y};    cc = 1'b0; oo = 1'b0; end
      default: begin r = {8'h00, y}; cc = 1'b0; oo = 1'b0; end
    endcase
    z = r == 16'h0000;
    n = op == 2'b11 ? r[15] : r[7];
    return {op, r, cc, oo, z, n};
  endfunction
  task automatic step();
    logic [21:0] e;
    bit push, pop;
    chk("in_ready", 32'(b.in_ready), 32'(q.size() < DEPTH));
    chk("out_valid", 32'(b.out_valid), 32'(q.size() != 0));
    chk("count", 32'(count), 32'(q.size()));
    e = q.size() != 0 ? q[0] : 22'h0;
    chk("head", 32'({b.out_opcode, b.out_result, b.out_c, b.out_o, b.out_z, b.out_n}), 32'(e));
`ifdef ALU_RES_STATS_EN
    chk("ovf_count", 32'(ovf_count), 32'(m_ovf));
    chk("cy_count", 32'(cy_count), 32'(m_cy));
`endif
    push = b.in_valid && q.size() < DEPTH;
    pop  = b.out_ready && q.size() != 0;
    if (pop) void'(q.pop_front());
    if (push) begin
      e = model(b.in_opcode, b.in_y, b.in_y1, b.in_c, b.in_o);
      q.push_back(e);
`ifdef ALU_RES_STATS_EN
      if (e[2] && m_ovf != 65535) m_ovf++;
      if (e[3] && m_cy != 65535) m_cy++;
`endif
    end
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] y, input logic [7:0] y1,
                       input logic c, input logic o, input logic rdy);
    b.in_valid  = v;
    b.in_opcode = op;
    b.in_y      = y;
    b.in_y1     = y1;
    b.in_c      = c;
    b.in_o      = o;
    b.out_ready = rdy;
    step();
  endtask
  task automatic drive_rand(input logic v, input logic rdy);
    drive(v, 2'($urandom_range(3)), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), rdy);
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_in_ready", 32'(b.in_ready), 32'd1);
    chk("reset_result", 32'(b.out_result), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 2'b00, 8'hFF, 8'h55, 1, 0, 0);
    chk("add_result", 32'(b.out_result), 32'h00FF);
    chk("add_flags", 32'({b.out_c, b.out_z, b.out_n}), 32'b101);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(1, 2'b11, 8'h00, 8'h00, 0, 0, 0);
    drive(1, 2'b11, 8'h01, 8'h80, 1, 1, 0);
    chk("mul0_zn", 32'({b.out_z, b.out_n}), 32'b10);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("mul1_result", 32'(b.out_result), 32'h8001);
    chk("mul1_zn", 32'({b.out_z, b.out_n}), 32'b01);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(1, 2'b10, 8'h00, 8'h77, 1, 1, 0);
    chk("xor_flags", 32'({b.out_c, b.out_o, b.out_z, b.out_n}), 32'b0010);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(1, 2'b01, 8'h80, 8'h12, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) drive_rand(1, 0);
    chk("full_ready", 32'(b.in_ready), 32'd0);
    for (int i = 0; i < 6; i++) drive_rand(1, 1);
    drive_rand(1, 0);
    chk("refill_count", 32'(count), 32'd4);
    for (int i = 0; i < 5; i++) drive_rand(0, 1);
    for (int i = 0; i < 3; i++) drive_rand(1, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(b.out_valid), 32'd0);
    chk("async_rst_count", 32'(count), 32'd0);
    q.delete();
`ifdef ALU_RES_STATS_EN
    m_ovf = 0;
    m_cy  = 0;
`endif
    #1 rst = 1'b0;
    drive_rand(1, 0);
    chk("post_rst_count", 32'(count), 32'd1);
    for (int i = 0; i < 300; i++) drive_rand(1'($urandom_range(1)), 1'($urandom_range(1)));
    for (int i = 0; i < 5; i++) drive_rand(0, 1);
    drive_rand(0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
